// File: rtl/rs15_9_pkg.sv
// Shared RS(15,9) definitions over GF(16) with field polynomial x^4+x+1.
package rs15_9_pkg;
   localparam int WORD_WIDTH = 4;
   localparam int N_NUM      = 15;
   localparam int K_NUM      = 9;
   localparam int N_SYND     = N_NUM - K_NUM;
   localparam int CW_WIDTH   = N_NUM * WORD_WIDTH;

   localparam logic [WORD_WIDTH-1:0] ALPHA_1 = 4'h2;
   localparam logic [WORD_WIDTH-1:0] ALPHA_2 = 4'h4;
   localparam logic [WORD_WIDTH-1:0] ALPHA_3 = 4'h8;
   localparam logic [WORD_WIDTH-1:0] ALPHA_4 = 4'h3;
   localparam logic [WORD_WIDTH-1:0] ALPHA_5 = 4'h6;
   localparam logic [WORD_WIDTH-1:0] ALPHA_6 = 4'hC;

   // Generator coefficients g5..g0 (a^10, a^14, a^4, a^6, a^9, a^6), shared with the encoder.
   localparam logic [WORD_WIDTH-1:0] GEN_COEF [0:5] = '{4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};

   // Root a^j used by syndrome cell j.
   function automatic logic [WORD_WIDTH-1:0] root_of(input int j);
      case (j)
         1:       root_of = ALPHA_1;
         2:       root_of = ALPHA_2;
         3:       root_of = ALPHA_3;
         4:       root_of = ALPHA_4;
         5:       root_of = ALPHA_5;
         6:       root_of = ALPHA_6;
         default: root_of = 4'h1;
      endcase
   endfunction
endpackage

// File: rtl/gf16_add.sv
// GF(16) adder: bitwise XOR.
module gf16_add (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [3:0] o_s
);
   assign o_s = i_a ^ i_b;
endmodule

// File: rtl/gf16_mul.sv
// General GF(16) multiplier, x^4+x+1, shift-and-add with reduction.
module gf16_mul (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [3:0] o_p
);
   logic [3:0] w_sh;

   // Accumulate a*x^i for each set bit of b, reducing x^4 -> x+1 as we shift.
   always_comb begin
      o_p  = 4'h0;
      w_sh = i_a;
      for (int i = 0; i < 4; i++) begin
         if (i_b[i]) o_p = o_p ^ w_sh;
         w_sh = {w_sh[2:0], 1'b0} ^ (w_sh[3] ? 4'h3 : 4'h0);
      end
   end
endmodule

// File: rtl/rs_synd_cell.sv
// One Horner accumulator: S <= S*ROOT + sym while enabled, cleared on start.
module rs_synd_cell
   import rs15_9_pkg::*;
#(
   parameter logic [WORD_WIDTH-1:0] ROOT = 4'h2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] sym,
   output logic [WORD_WIDTH-1:0] S,
   output logic [WORD_WIDTH-1:0] s_next
);
   logic [WORD_WIDTH-1:0] w_prod;
   logic [WORD_WIDTH-1:0] w_sum;

   gf16_mul u_mul (.i_a(S), .i_b(ROOT), .o_p(w_prod));
   gf16_add u_add (.i_a(w_prod), .i_b(sym), .o_s(w_sum));

   // Value S takes on the next edge; the top uses it to form the error flag in step with the result.
   assign s_next = clr ? '0 : (en ? w_sum : S);

   // Accumulator register; holds when idle so the result stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) S <= '0;
      else        S <= s_next;
   end
endmodule

// File: rtl/rs_syndrome.sv
// RS(15,9) syndrome calculator: evaluates the codeword at a^1..a^6 over 15 symbol cycles.
module rs_syndrome
   import rs15_9_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           data_en,
   input  logic [CW_WIDTH-1:0]            codein,
   output logic                           busy,
   output logic                           synd_rdy,
   output logic [N_SYND*WORD_WIDTH-1:0]   syndromes,
   output logic                           err_flag
);
   localparam logic [3:0] CNT_LOAD = 4'(N_NUM);

   logic                         r_data_en_reg;
   logic                         r_armed;
   logic [3:0]                   r_cnt;
   logic [CW_WIDTH-1:0]          r_shift;
   logic                         r_busy;
   logic                         r_synd_rdy;
   logic                         r_err;
   logic                         w_start;
   logic                         w_run;
   logic [N_SYND*WORD_WIDTH-1:0] w_s_nxt;

   // r_armed records that data_en has been seen low since reset, so a level
   // already high at reset release is not mistaken for a rising edge.
   assign w_start = data_en & ~r_data_en_reg & r_armed & ~r_busy;
   assign w_run   = (r_cnt != 4'd0);

   // Edge-detect history of data_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_en_reg <= 1'b0;
         r_armed       <= 1'b0;
      end else begin
         r_data_en_reg <= data_en;
         if (!data_en) r_armed <= 1'b1;
      end
   end

   // Symbol counter, shift register and ready/busy handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 4'd0;
         r_shift    <= '0;
         r_busy     <= 1'b0;
         r_synd_rdy <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_start) begin
         r_shift    <= codein;
         r_cnt      <= CNT_LOAD;
         r_busy     <= 1'b1;
         r_synd_rdy <= 1'b0;
      end else if (w_run) begin
         r_shift <= {r_shift[CW_WIDTH-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
         r_cnt   <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            r_busy     <= 1'b0;
            r_synd_rdy <= 1'b1;
            r_err      <= |w_s_nxt;
         end
      end
   end

   for (genvar j = 1; j <= N_SYND; j++) begin : g_cell
      rs_synd_cell #(.ROOT(root_of(j))) u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (w_start),
         .en     (w_run),
         .sym    (r_shift[CW_WIDTH-1 -: WORD_WIDTH]),
         .S      (syndromes[WORD_WIDTH*j-1 -: WORD_WIDTH]),
         .s_next (w_s_nxt[WORD_WIDTH*j-1 -: WORD_WIDTH])
      );
   end

   assign busy     = r_busy;
   assign synd_rdy = r_synd_rdy;
   assign err_flag = r_err;
endmodule

// File: tb/tb_rs_syndrome.sv
module tb_rs_syndrome;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_en = 1'b0;
   logic [59:0] codein = '0;
   logic        busy;
   logic        synd_rdy;
   logic [23:0] syndromes;
   logic        err_flag;

   int n_checks = 0;
   int n_fail   = 0;

   rs_syndrome dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_en   (data_en),
      .codein    (codein),
      .busy      (busy),
      .synd_rdy  (synd_rdy),
      .syndromes (syndromes),
      .err_flag  (err_flag)
   );

   always #5 clk = ~clk;

   // GF(16) antilog / log tables, x^4+x+1.
   logic [3:0] exp_t [0:14];
   int         log_t [0:15];

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      if (a == 4'h0 || b == 4'h0) return 4'h0;
      return exp_t[(log_t[a] + log_t[b]) % 15];
   endfunction

   // Direct polynomial evaluation: S_j = sum_i c_i * a^(i*j).
   function automatic logic [23:0] eval_synd(input logic [59:0] cw);
      logic [23:0] s;
      logic [3:0]  acc;
      s = '0;
      for (int j = 1; j <= 6; j++) begin
         acc = 4'h0;
         for (int i = 0; i < 15; i++) acc = acc ^ gmul(cw[4*i +: 4], exp_t[(i*j) % 15]);
         s[4*j-4 +: 4] = acc;
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: a start needs data_en sampled low earlier (prev starts "high" after reset).
   logic        m_prev = 1'b1;
   int          m_left = 0;
   logic        m_rdy  = 1'b0;
   logic [23:0] m_pend = '0;
   logic [23:0] m_res  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev <= 1'b1;
         m_left <= 0;
         m_rdy  <= 1'b0;
      end else begin
         m_prev <= data_en;
         if (data_en && !m_prev && m_left == 0) begin
            m_left <= 15;
            m_rdy  <= 1'b0;
            m_pend <= eval_synd(codein);
         end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_rdy <= 1'b1;
               m_res <= m_pend;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_rdy", 64'(synd_rdy), 64'd0);
         chk("rst_synd", 64'(syndromes), 64'd0);
         chk("rst_err", 64'(err_flag), 64'd0);
      end else begin
         chk("busy", 64'(busy), 64'(m_left != 0));
         chk("synd_rdy", 64'(synd_rdy), 64'(m_rdy));
         if (m_rdy) begin
            chk("syndromes", 64'(syndromes), 64'(m_res));
            chk("err_flag", 64'(err_flag), 64'(m_res != 24'h0));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic run_cw(input logic [59:0] cw, input logic [23:0] exp_s, input string nm);
      int nb;
      bit done;
      nb   = 0;
      done = 0;
      codein  = cw;
      data_en = 1'b1;
      tick(1);
      data_en = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (synd_rdy) begin
            done = 1;
            break;
         end
         if (busy) nb++;
      end
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_busy_cycles"}, 64'(nb), 64'd15);
      chk({nm, "_synd"}, 64'(syndromes), 64'(exp_s));
      chk({nm, "_err"}, 64'(err_flag), 64'(exp_s != 24'h0));
      tick(1);
   endtask

   initial begin
      exp_t[0] = 4'h1;
      for (int i = 1; i < 15; i++)
         exp_t[i] = {exp_t[i-1][2:0], 1'b0} ^ (exp_t[i-1][3] ? 4'h3 : 4'h0);
      log_t[0] = 0;
      for (int i = 0; i < 15; i++) log_t[exp_t[i]] = i;

      chk("model_c0", 64'(eval_synd(60'h1)), 64'h111111);
      chk("model_c1", 64'(eval_synd(60'h10)), 64'hC63842);
      chk("model_c14", 64'(eval_synd(60'h100000000000000)), 64'hA7EFD9);
      chk("model_gx", 64'(eval_synd(60'h000000001793CAC)), 64'h0);

      rst_n = 1'b0;
      #1;
      chk("por_busy", 64'(busy), 64'd0);
      chk("por_rdy", 64'(synd_rdy), 64'd0);
      chk("por_synd", 64'(syndromes), 64'd0);
      tick(3);
      rst_n = 1'b1;
      tick(3);

      run_cw(60'h0, 24'h000000, "zero");
      run_cw(60'h000000001793CAC, 24'h000000, "gx");
      run_cw(60'h000000000000001, 24'h111111, "err_c0");
      run_cw(60'h000000000000010, 24'hC63842, "err_c1");
      run_cw(60'h100000000000000, 24'hA7EFD9, "err_c14");

      // Retrigger while busy is ignored; a new edge at T+16 is accepted.
      codein = 60'h1; data_en = 1'b1;
      tick(1);
      data_en = 1'b0;
      tick(4);
      codein = 60'h10; data_en = 1'b1;
      tick(1);
      data_en = 1'b0;
      tick(10);
      chk("retrig_rdy_t15", 64'(synd_rdy), 64'd1);
      chk("retrig_synd_t15", 64'(syndromes), 64'h111111);
      codein = 60'h10; data_en = 1'b1;
      tick(1);
      chk("t16_rdy_drop", 64'(synd_rdy), 64'd0);
      chk("t16_busy", 64'(busy), 64'd1);
      data_en = 1'b0;
      tick(14);
      chk("t30_not_rdy", 64'(synd_rdy), 64'd0);
      tick(1);
      chk("t31_rdy", 64'(synd_rdy), 64'd1);
      chk("t31_synd", 64'(syndromes), 64'hC63842);
      tick(2);

      // Reset in mid-computation aborts and leaves no result.
      codein = 60'h100000000000000; data_en = 1'b1;
      tick(1);
      data_en = 1'b0;
      tick(6);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rdy", 64'(synd_rdy), 64'd0);
      chk("abort_synd", 64'(syndromes), 64'd0);
      chk("abort_err", 64'(err_flag), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("abort_no_rdy", 64'(synd_rdy), 64'd0);
      run_cw(60'h1, 24'h111111, "after_abort");

      // data_en already high at reset release must not start.
      rst_n = 1'b0; data_en = 1'b1; codein = 60'h10;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("hi_release_busy", 64'(busy), 64'd0);
      chk("hi_release_rdy", 64'(synd_rdy), 64'd0);
      data_en = 1'b0;
      tick(2);
      run_cw(60'h10, 24'hC63842, "after_hi");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
